// File: rtl/bus_arbiter_rr_if.sv
// rtl/bus_arbiter_rr_if.sv - request/grant bundle between bus masters and the round-robin arbiter
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2
);
    // Active-low per-master request, lock and grant vectors
    logic [NUM_MASTERS-1:0] m_req_;
    logic [NUM_MASTERS-1:0] m_lock_;
    logic [NUM_MASTERS-1:0] m_grnt_;
    logic [OWNER_W-1:0]     owner;
    logic                   handover;

    // Master side drives requests/locks and observes the grant
    modport master (
        output m_req_,
        output m_lock_,
        input  m_grnt_,
        input  owner,
        input  handover
    );

    // Arbiter side samples requests/locks and drives the grant
    modport slave (
        input  m_req_,
        input  m_lock_,
        output m_grnt_,
        output owner,
        output handover
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with parking; optional tenure limit via BUS_ARB_TENURE_LIMIT_EN
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int MAX_TENURE  = 16,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_rr_if.slave  bus
);
    localparam logic [OWNER_W:0] NUM_M = (OWNER_W+1)'(NUM_MASTERS);

    logic [OWNER_W-1:0]       r_owner;
    logic                     r_handover;
    logic [OWNER_W-1:0]       w_next_owner;
    logic [NUM_MASTERS-1:0]   w_req;
    logic [NUM_MASTERS-1:0]   w_owner_dec;
    logic [NUM_MASTERS-1:0]   w_rot;
    logic                     w_own_req;
    logic                     w_other_req;
    logic                     w_force;
    logic                     w_found;
    logic [OWNER_W:0]         w_sum;

    assign w_req       = ~bus.m_req_;
    assign w_owner_dec = NUM_MASTERS'(1) << r_owner;
    // Rotated request view: bit i is master (owner+i) mod NUM_MASTERS, so bit 0 is the owner
    assign w_rot       = NUM_MASTERS'({w_req, w_req} >> r_owner);
    assign w_own_req   = w_rot[0];
    assign w_other_req = |w_rot[NUM_MASTERS-1:1];

`ifdef BUS_ARB_TENURE_LIMIT_EN
    localparam logic [CNT_W-1:0] TCNT_MAX = CNT_W'(MAX_TENURE - 1);

    logic [CNT_W-1:0] r_tcnt;
    logic             w_own_unlocked;

    // Lock inputs are active-low, so a high bit at the owner means it may be preempted
    assign w_own_unlocked = |(bus.m_lock_ & w_owner_dec);
    assign w_force        = (r_tcnt == TCNT_MAX) && w_own_unlocked && w_other_req;

    // Tenure counter: restarts on every owner change, saturates at MAX_TENURE-1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (w_next_owner != r_owner) begin
            r_tcnt <= '0;
        end else if (r_tcnt != TCNT_MAX) begin
            r_tcnt <= r_tcnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_cfg;

    assign w_force      = 1'b0;
    assign w_unused_cfg = ^{bus.m_lock_, CNT_W'(MAX_TENURE - 1)};
`endif

    // Owner and handover pulse registers; reset parks the bus on master 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= '0;
            r_handover <= 1'b0;
        end else begin
            r_owner    <= w_next_owner;
            r_handover <= (w_next_owner != r_owner);
        end
    end

    // Next owner: keep a requesting owner unless forced, else first requester after it in rotation
    always_comb begin
        w_next_owner = r_owner;
        w_found      = 1'b0;
        w_sum        = '0;
        if (!w_own_req || w_force) begin
            for (int i = 1; i < NUM_MASTERS; i++) begin
                if (!w_found && w_rot[i]) begin
                    w_found = 1'b1;
                    w_sum   = {1'b0, r_owner} + (OWNER_W+1)'(i);
                    if (w_sum >= NUM_M) begin
                        w_sum = w_sum - NUM_M;
                    end
                    w_next_owner = w_sum[OWNER_W-1:0];
                end
            end
        end
    end

    // Outputs decode from registers only, so no request-to-grant combinational path
    always_comb begin
        bus.m_grnt_  = ~w_owner_dec;
        bus.owner    = r_owner;
        bus.handover = r_handover;
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr
module tb_bus_arbiter_rr;
    logic clk = 1'b0;
    logic reset;
    logic reset3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr_if #(.NUM_MASTERS(4), .OWNER_W(2)) bus4 ();
    bus_arbiter_rr_if #(.NUM_MASTERS(3), .OWNER_W(2)) bus3 ();

    bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_TENURE(4), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    bus_arbiter_rr #(.NUM_MASTERS(3), .OWNER_W(2), .MAX_TENURE(4), .CNT_W(2)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [1:0] own, input logic ho);
        logic [3:0] g;
        g = ~(4'b0001 << own);
        check({tag, "_owner"}, 32'(bus4.owner), 32'(own));
        check({tag, "_grnt"}, 32'(bus4.m_grnt_), 32'(g));
        check({tag, "_ho"}, 32'(bus4.handover), 32'(ho));
    endtask

    initial begin
        reset        = 1'b1;
        reset3       = 1'b1;
        bus4.m_req_  = 4'b1111;
        bus4.m_lock_ = 4'b1111;
        bus3.m_req_  = 3'b111;
        bus3.m_lock_ = 3'b111;
        step();
        step();
        reset  = 1'b0;
        reset3 = 1'b0;

        check4("reset", 2'd0, 1'b0);
        check("reset_grnt_lit", 32'(bus4.m_grnt_), 32'h e);

        for (int k = 0; k < 10; k++) begin
            step();
            check4("park", 2'd0, 1'b0);
        end

`ifndef BUS_ARB_TENURE_LIMIT_EN
        bus4.m_req_ = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            check4("all_req_hold", 2'd0, 1'b0);
        end
`endif

        bus4.m_req_ = 4'b0001;
        step();
        check4("release0", 2'd1, 1'b1);
        step();
        check4("release0_next", 2'd1, 1'b0);

        bus4.m_req_ = 4'b0111;
        step();
        check4("to3", 2'd3, 1'b1);
        bus4.m_req_ = 4'b1010;
        #2;
        check("no_comb_path", 32'(bus4.m_grnt_), 32'h7);
        step();
        check4("wrap_to0", 2'd0, 1'b1);

        bus4.m_req_ = 4'b1101;
        step();
        check4("hop1", 2'd1, 1'b1);
        bus4.m_req_ = 4'b1011;
        step();
        check4("hop2", 2'd2, 1'b1);
        bus4.m_req_ = 4'b1111;
        step();
        check4("park2", 2'd2, 1'b0);

        bus4.m_req_ = 4'b1011;
        step();
        check4("own2_req", 2'd2, 1'b0);
        reset = 1'b1;
        step();
        check4("mid_reset", 2'd0, 1'b0);
`ifdef BUS_ARB_TENURE_LIMIT_EN
        check("mid_reset_tcnt", 32'(dut.r_tcnt), 32'd0);
`endif
        reset = 1'b0;

        bus3.m_req_ = 3'b011;
        step();
        check("n3_to2", 32'(bus3.owner), 32'd2);
        check("n3_to2_grnt", 32'(bus3.m_grnt_), 32'h3);
        bus3.m_req_ = 3'b110;
        step();
        check("n3_wrap", 32'(bus3.owner), 32'd0);
        check("n3_wrap_grnt", 32'(bus3.m_grnt_), 32'h6);
        check("n3_wrap_ho", 32'(bus3.handover), 32'd1);

`ifdef BUS_ARB_TENURE_LIMIT_EN
        bus4.m_req_ = 4'b1111;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus4.m_req_ = 4'b1100;
        for (int k = 1; k <= 12; k++) begin
            step();
            check4("tenure_alt", 2'((k / 4) % 2), (k % 4) == 0);
        end

        bus4.m_req_ = 4'b1111;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus4.m_req_  = 4'b1100;
        bus4.m_lock_ = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            step();
            check4("locked_hold", 2'd0, 1'b0);
        end
        bus4.m_lock_ = 4'b1111;
        step();
        check4("lock_release", 2'd1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised round-robin bus arbiter for the shared system bus: it grants exactly one of NUM_MASTERS bus masters at any time and parks the grant on the last owner when nobody requests. It replaces the fixed four-master arbiter between the master ports and the bus multiplexers. An optional tenure limit forces a hand-over when one master holds the bus too long while others wait.

## Interface
- NUM_MASTERS, 4: number of bus masters, 2..16.
- OWNER_W, 2: owner index width, equal to ceil(log2(NUM_MASTERS)).
- MAX_TENURE, 16: maximum consecutive owned cycles before forced hand-over, 2..256; used only with the tenure limit compiled in.
- CNT_W, 4: tenure counter width, equal to ceil(log2(MAX_TENURE)).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- m_req_  in  NUM_MASTERS  bus request per master, active-low.
- m_lock_  in  NUM_MASTERS  locked-transfer hold per master, active-low; protects the owner from forced hand-over.
- m_grnt_  out  NUM_MASTERS  bus grant per master, active-low, one-hot-low.
- owner  out  OWNER_W  index of the current owner (registered).
- handover  out  1  one-cycle pulse, registered; high in the first cycle of a new owner's tenure.

## Operation
- owner is the only arbitration state. m_grnt_ is a combinational decode of owner: bit owner low, all other bits high. Exactly one grant is always active, including when no master requests (parking).
- Next-owner rule, evaluated every clk edge:
  - If the current owner requests and no forced hand-over applies, owner is unchanged.
  - Otherwise search masters owner+1, owner+2, ... modulo NUM_MASTERS. The first requesting master becomes owner.
  - If no master other than the owner requests, owner is unchanged (park), whether or not the owner requests.
- Masters with an index at or above NUM_MASTERS do not exist. The search wraps at NUM_MASTERS-1 to 0, not at 2^OWNER_W-1.
- handover is 1 for the cycle after any owner change and 0 otherwise.
- Tenure counter tcnt (CNT_W bits, internal):
  - Cleared to 0 on an owner change.
  - Otherwise increments each cycle, saturating at MAX_TENURE-1.
- Reset values: owner=0, m_grnt_ = all ones except bit 0 low, handover=0, tcnt=0.
- If reset is asserted mid-tenure, the next edge unconditionally returns owner to master 0, independent of the request inputs.

## Timing
- Arbitration latency: 1 cycle. A request sampled at edge n yields a grant valid after edge n, provided the owner has released.
- A master that releases its request at edge n loses the grant after edge n if another master requests. The bus may change hands every cycle.
- Simultaneous requests are resolved strictly by rotation distance from the current owner. There is no fixed priority.
- Worst-case wait, with the tenure limit compiled in and no locks: (NUM_MASTERS-1) x MAX_TENURE cycles.
- No combinational path from m_req_ to m_grnt_. The grants depend on registers only.

## Configuration
- BUS_ARB_TENURE_LIMIT_EN defined:
  - When tcnt == MAX_TENURE-1, the owner's m_lock_ is high, and any other master requests, the next edge forces the rotation search starting at owner+1 even though the owner still requests.
  - The preempted master keeps its request and is re-granted in normal rotation.
  - While the owner's m_lock_ is low, tcnt still saturates but no forced hand-over occurs. Forced hand-over happens at the first edge after lock release, if others still request.
- BUS_ARB_TENURE_LIMIT_EN undefined:
  - tcnt and the forced hand-over logic are absent, and m_lock_ is ignored.
  - The owner keeps the bus for as long as it requests.

## Test plan
- Reset, no requests -> m_grnt_=4'b1110, owner=0, handover=0; grant parks on master 0 for 10 cycles.
- m_req_=4'b0000 continuously, owner=0, limit undefined -> owner stays 0 forever. Master 0 releases (4'b0001) -> owner=1 after one edge, handover pulses 1 cycle.
- Owner=3, m_req_=4'b1010 (masters 0 and 2 request) -> next owner is 0 (wrap), not 2. NUM_MASTERS=3 build, owner=2, m_req_=3'b110 -> owner=0.
- Limit defined, MAX_TENURE=4, masters 0 and 1 requesting continuously -> ownership alternates 0,1,0,1 with exactly 4 cycles of grant each; handover pulses every 4 cycles.
- Same setup, m_lock_[0]=0 held for 10 cycles -> master 0 keeps the grant for 10 cycles, then loses it 1 edge after lock release.
- Reset asserted while owner=2 with m_req_=4'b1011 -> owner=0 and grant bit 0 low after that edge; tcnt=0, handover=0.
